// File: rtl/cpu_if_arbiter.sv
// Round-robin arbiter that shares one CPU_IF target among NUM_MASTERS
// initiators. It holds address and write data for the target across the
// access, and returns completion and read data to the granted initiator. A bus
// timeout aborts accesses to a target that never completes.
module cpu_if_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF,
  localparam int unsigned GW            = $clog2(NUM_MASTERS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_MASTERS-1:0]    m_cpu_if_read,
  input  logic [NUM_MASTERS-1:0]    m_cpu_if_write,
  input  logic [NUM_MASTERS*32-1:0] m_cpu_if_write_data,
  input  logic [NUM_MASTERS*30-1:0] m_cpu_if_address,
  output logic [31:0]               m_cpu_if_read_data,
  output logic [NUM_MASTERS-1:0]    m_cpu_if_access_complete,
  output logic                      cpu_if_read,
  output logic                      cpu_if_write,
  output logic [31:0]               cpu_if_write_data,
  output logic [29:0]               cpu_if_address,
  input  logic [31:0]               cpu_if_read_data,
  input  logic                      cpu_if_access_complete,
  output logic [GW-1:0]             grant_id,
  output logic                      busy,
  output logic                      timeout_error
);

  // Round-robin search sum needs one extra bit so ptr+i never overflows.
  localparam int unsigned SW = GW + 1;
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] N_SUM    = SW'(NUM_MASTERS);
  localparam logic [GW-1:0] LAST_IDX = GW'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           ptr_q, ptr_d;
  logic [GW-1:0]           grant_d;
  logic [CW-1:0]           tcnt_q, tcnt_d;
  logic                    is_write_q, is_write_d;
  logic [29:0]             addr_d;
  logic [31:0]             wdata_d;
  logic [31:0]             rdata_d;
  logic                    rd_d, wr_d, terr_d;
  logic [NUM_MASTERS-1:0]  mcomp_d;
  logic [NUM_MASTERS-1:0]  req;
  logic [SW-1:0]           sum;
  logic [GW-1:0]           pick;
  logic                    found;

  logic [31:0] wdata_arr [NUM_MASTERS];
  logic [29:0] addr_arr  [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign wdata_arr[g] = m_cpu_if_write_data[g*32 +: 32];
    assign addr_arr[g]  = m_cpu_if_address[g*30 +: 30];
  end

  assign req = m_cpu_if_read | m_cpu_if_write;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_id;
    tcnt_d     = tcnt_q;
    is_write_d = is_write_q;
    addr_d     = cpu_if_address;
    wdata_d    = cpu_if_write_data;
    rdata_d    = m_cpu_if_read_data;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    terr_d     = 1'b0;
    mcomp_d    = '0;
    sum        = '0;
    pick       = '0;
    found      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // First requester at or after ptr, wrapping modulo NUM_MASTERS.
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
          sum = {1'b0, ptr_q} + SW'(i);
          if (sum >= N_SUM) sum = sum - N_SUM;
          if (!found && req[sum[GW-1:0]]) begin
            found = 1'b1;
            pick  = sum[GW-1:0];
          end
        end
        if (found) begin
          grant_d    = pick;
          addr_d     = addr_arr[pick];
          wdata_d    = wdata_arr[pick];
          is_write_d = m_cpu_if_write[pick];
          wr_d       = m_cpu_if_write[pick];
          rd_d       = ~m_cpu_if_write[pick];
          tcnt_d     = '0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ptr_d  = (grant_id == LAST_IDX) ? '0 : grant_id + GW'(1);
        tcnt_d = tcnt_q + CW'(1);
        if (cpu_if_access_complete) begin
          rdata_d           = cpu_if_read_data;
          mcomp_d[grant_id] = 1'b1;
          state_d           = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cpu_if_access_complete) begin
          rdata_d           = cpu_if_read_data;
          mcomp_d[grant_id] = 1'b1;
          state_d           = ST_DONE;
        end else if (TIMEOUT_CYCLES != 0 && tcnt_q == TO_LIMIT) begin
          rdata_d           = TIMEOUT_DATA;
          mcomp_d[grant_id] = 1'b1;
          terr_d            = 1'b1;
          state_d           = ST_DONE;
        end else begin
          tcnt_d = tcnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q                  <= ST_IDLE;
      ptr_q                    <= '0;
      tcnt_q                   <= '0;
      is_write_q               <= 1'b0;
      grant_id                 <= '0;
      cpu_if_address           <= '0;
      cpu_if_write_data        <= '0;
      m_cpu_if_read_data       <= '0;
      cpu_if_read              <= 1'b0;
      cpu_if_write             <= 1'b0;
      m_cpu_if_access_complete <= '0;
      timeout_error            <= 1'b0;
      busy                     <= 1'b0;
    end else begin
      state_q                  <= state_d;
      ptr_q                    <= ptr_d;
      tcnt_q                   <= tcnt_d;
      is_write_q               <= is_write_d;
      grant_id                 <= grant_d;
      cpu_if_address           <= addr_d;
      cpu_if_write_data        <= wdata_d;
      m_cpu_if_read_data       <= rdata_d;
      cpu_if_read              <= rd_d;
      cpu_if_write             <= wr_d;
      m_cpu_if_access_complete <= mcomp_d;
      timeout_error            <= terr_d;
      busy                     <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_cpu_if_arbiter.sv
// Directed bench for cpu_if_arbiter: one instance with the default timeout
// for arbitration/hold tests and one with an 8-cycle timeout.
module tb_cpu_if_arbiter;

  logic clk = 1'b0;
  logic reset;

  // Main instance
  logic [1:0]  m_rd, m_wr, m_comp;
  logic [63:0] m_wdata;
  logic [59:0] m_addr;
  logic [31:0] m_rdata;
  logic        cpu_rd, cpu_wr, cpu_comp;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic [29:0] cpu_addr;
  logic [0:0]  gid;
  logic        busy, terr;

  // Timeout instance
  logic [1:0]  t_m_rd, t_m_wr, t_m_comp;
  logic [63:0] t_m_wdata;
  logic [59:0] t_m_addr;
  logic [31:0] t_m_rdata;
  logic        t_cpu_rd, t_cpu_wr, t_cpu_comp;
  logic [31:0] t_cpu_wdata, t_cpu_rdata;
  logic [29:0] t_cpu_addr;
  logic [0:0]  t_gid;
  logic        t_busy, t_terr;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_if_arbiter #(
    .NUM_MASTERS(2),
    .TIMEOUT_CYCLES(256),
    .TIMEOUT_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .reset(reset),
    .m_cpu_if_read(m_rd), .m_cpu_if_write(m_wr),
    .m_cpu_if_write_data(m_wdata), .m_cpu_if_address(m_addr),
    .m_cpu_if_read_data(m_rdata), .m_cpu_if_access_complete(m_comp),
    .cpu_if_read(cpu_rd), .cpu_if_write(cpu_wr),
    .cpu_if_write_data(cpu_wdata), .cpu_if_address(cpu_addr),
    .cpu_if_read_data(cpu_rdata), .cpu_if_access_complete(cpu_comp),
    .grant_id(gid), .busy(busy), .timeout_error(terr)
  );

  cpu_if_arbiter #(
    .NUM_MASTERS(2),
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_DATA(32'hDEAD_BEEF)
  ) dut_to (
    .clk(clk), .reset(reset),
    .m_cpu_if_read(t_m_rd), .m_cpu_if_write(t_m_wr),
    .m_cpu_if_write_data(t_m_wdata), .m_cpu_if_address(t_m_addr),
    .m_cpu_if_read_data(t_m_rdata), .m_cpu_if_access_complete(t_m_comp),
    .cpu_if_read(t_cpu_rd), .cpu_if_write(t_cpu_wr),
    .cpu_if_write_data(t_cpu_wdata), .cpu_if_address(t_cpu_addr),
    .cpu_if_read_data(t_cpu_rdata), .cpu_if_access_complete(t_cpu_comp),
    .grant_id(t_gid), .busy(t_busy), .timeout_error(t_terr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    m_rd = '0; m_wr = '0; m_wdata = '0; m_addr = '0;
    cpu_rdata = '0; cpu_comp = 1'b0;
    t_m_rd = '0; t_m_wr = '0; t_m_wdata = '0; t_m_addr = '0;
    t_cpu_rdata = '0; t_cpu_comp = 1'b0;
    tick(); tick();

    // Reset values
    check("rst_strobes", {cpu_rd, cpu_wr}, 2'b00);
    check("rst_comp", m_comp, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_gid", gid, 1'b0);
    check("rst_addr", cpu_addr, 30'h0);
    check("rst_rdata", m_rdata, 32'h0);
    check("rst_terr", terr, 1'b0);
    check("rst_t", {t_busy, t_terr, t_m_comp}, 4'b0000);
    reset = 1'b0;
    tick();

    // Single read from initiator 1, target completes 2 cycles after strobe
    m_rd = 2'b10;
    m_addr[59:30] = 30'h100;
    tick();
    check("rd_strobe", {cpu_rd, cpu_wr}, 2'b10);
    check("rd_addr", cpu_addr, 30'h100);
    check("rd_gid", gid, 1'b1);
    check("rd_busy", busy, 1'b1);
    tick();
    check("rd_one_strobe", {cpu_rd, cpu_wr}, 2'b00);
    check("rd_no_early_comp", m_comp, 2'b00);
    tick();
    cpu_comp = 1'b1; cpu_rdata = 32'h1234_5678;
    tick();
    cpu_comp = 1'b0; cpu_rdata = '0;
    check("rd_comp", m_comp, 2'b10);
    check("rd_data", m_rdata, 32'h1234_5678);
    m_rd = 2'b00;
    tick();
    check("rd_comp_pulse", m_comp, 2'b00);
    check("rd_idle", busy, 1'b0);

    // Contention from reset: grants 0, 1, 0 with zero-wait target
    reset = 1'b1; tick(); reset = 1'b0;
    m_rd = 2'b11;
    m_addr = {30'h20, 30'h10};
    tick();
    check("cont_gid0", gid, 1'b0);
    check("cont_addr0", cpu_addr, 30'h10);
    cpu_comp = 1'b1; cpu_rdata = 32'hA0;
    tick();
    cpu_comp = 1'b0;
    check("cont_comp0", m_comp, 2'b01);
    check("cont_data0", m_rdata, 32'hA0);
    m_rd[0] = 1'b0;
    tick();
    m_rd[0] = 1'b1;
    tick();
    check("cont_gid1", gid, 1'b1);
    check("cont_addr1", cpu_addr, 30'h20);
    cpu_comp = 1'b1; cpu_rdata = 32'hB1;
    tick();
    cpu_comp = 1'b0;
    check("cont_comp1", m_comp, 2'b10);
    check("cont_data1", m_rdata, 32'hB1);
    m_rd[1] = 1'b0;
    tick();
    m_rd[1] = 1'b1;
    tick();
    check("cont_gid2", gid, 1'b0);
    check("cont_addr2", cpu_addr, 30'h10);
    cpu_comp = 1'b1; cpu_rdata = 32'hC2;
    tick();
    cpu_comp = 1'b0;
    check("cont_comp2", m_comp, 2'b01);
    m_rd = 2'b00;
    tick();

    // Write hold: completion 10 cycles after strobe
    m_wr = 2'b01;
    m_wdata[31:0] = 32'hCAFE_F00D;
    m_addr = '0;
    m_addr[29:0] = 30'h3C;
    tick();
    check("wr_strobe", {cpu_rd, cpu_wr}, 2'b01);
    check("wr_addr", cpu_addr, 30'h3C);
    check("wr_data", cpu_wdata, 32'hCAFE_F00D);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("wr_hold", {cpu_wr, cpu_rd, cpu_addr, cpu_wdata}, {2'b00, 30'h3C, 32'hCAFE_F00D});
      if (k == 10) cpu_comp = 1'b1;
    end
    tick();
    cpu_comp = 1'b0;
    check("wr_comp", m_comp, 2'b01);
    m_wr = 2'b00;
    tick();

    // Read and write together is a write
    m_rd = 2'b01; m_wr = 2'b01;
    m_wdata[31:0] = 32'h0000_55AA;
    m_addr[29:0] = 30'h7;
    tick();
    check("rw_strobe", {cpu_rd, cpu_wr}, 2'b01);
    check("rw_data", cpu_wdata, 32'h0000_55AA);
    cpu_comp = 1'b1;
    tick();
    cpu_comp = 1'b0;
    check("rw_comp", m_comp, 2'b01);
    m_rd = 2'b00; m_wr = 2'b00;
    tick();

    // Reset during WAIT; ptr is 1 at this point so a post-reset grant of 0
    // shows the pointer was cleared
    m_rd = 2'b01;
    m_addr[29:0] = 30'h44;
    tick();
    tick();
    check("mid_wait_busy", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_addr", cpu_addr, 30'h0);
    check("mid_rst_gid", gid, 1'b0);
    m_rd = 2'b00;
    cpu_comp = 1'b1;
    tick();
    check("mid_rst_comp", m_comp, 2'b00);
    reset = 1'b0;
    tick();
    check("late_comp_ignored", {m_comp, busy}, 3'b000);
    cpu_comp = 1'b0;
    m_rd = 2'b11;
    m_addr = {30'h66, 30'h55};
    tick();
    check("post_rst_gid", gid, 1'b0);
    check("post_rst_addr", cpu_addr, 30'h55);
    cpu_comp = 1'b1; cpu_rdata = 32'h77;
    tick();
    cpu_comp = 1'b0;
    check("post_rst_comp", m_comp, 2'b01);
    m_rd = 2'b00;
    tick();

    // Timeout with TIMEOUT_CYCLES = 8; target never completes
    t_m_rd = 2'b01;
    t_m_addr[29:0] = 30'h5;
    tick();
    check("to_strobe", {t_cpu_rd, t_cpu_wr}, 2'b10);
    repeat (8) tick();
    check("to_no_early", {t_m_comp, t_terr}, 3'b000);
    tick();
    check("to_comp", t_m_comp, 2'b01);
    check("to_data", t_m_rdata, 32'hDEAD_BEEF);
    check("to_terr", t_terr, 1'b1);
    t_m_rd = 2'b00;
    tick();
    check("to_terr_pulse", {t_terr, t_busy}, 2'b00);
    tick();
    tick();
    t_cpu_comp = 1'b1; t_cpu_rdata = 32'h99;
    tick();
    t_cpu_comp = 1'b0;
    check("to_late_ignored", {t_m_comp, t_terr, t_busy}, 4'b0000);
    check("to_late_data_kept", t_m_rdata, 32'hDEAD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
